// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states, owner codes and
// 4-bit counter type with a saturating increment.
package mem_arb_pkg;

    localparam int unsigned CNT_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [1:0]       state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StIssue = 2'd1;
    localparam state_t StWait  = 2'd2;
    localparam state_t StResp  = 2'd3;

    localparam logic OWNER_CORE = 1'b0;
    localparam logic OWNER_DMA  = 1'b1;

    localparam cnt_t CNT_MAX = '1;

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == CNT_MAX) ? v : v + cnt_t'(1);
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Combinational winner select between core and DMA requesters.
// With MEM_ARB_DMA_LOCK_EN defined, an active DMA lock also forces a DMA grant.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic c_req,
    input  logic d_req,
    input  cnt_t starve_cnt,
`ifdef MEM_ARB_DMA_LOCK_EN
    input  logic lock_active,
`endif
    output logic grant_valid,
    output logic grant_owner
);

    localparam cnt_t StarveMax = cnt_t'(STARVE_MAX);

    logic starve_hit;
    logic dma_first;

    assign starve_hit = (starve_cnt >= StarveMax);

`ifdef MEM_ARB_DMA_LOCK_EN
    assign dma_first = d_req & (lock_active | starve_hit);
`else
    assign dma_first = d_req & starve_hit;
`endif

    assign grant_valid = c_req | d_req;
    // Core wins by default; DMA only when it is forced or the core is absent.
    assign grant_owner = (dma_first | ~c_req) ? OWNER_DMA : OWNER_CORE;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the unified memory: fixed-latency issue/wait/respond
// sequencing with starvation relief. MEM_ARB_DMA_LOCK_EN adds a DMA burst lock.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
`ifdef MEM_ARB_DMA_LOCK_EN
    ,
    parameter int unsigned LOCK_MAX   = 8
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic [DW-1:0] c_rdata,
    output logic          c_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          busy,
    output logic          owner
`ifdef MEM_ARB_DMA_LOCK_EN
    ,
    input  logic          d_lock
`endif
);

    localparam cnt_t MemLatM1 = cnt_t'(MEM_LAT - 1);

    state_t        state_q, state_d;
    cnt_t          wait_cnt_q, wait_cnt_d;
    cnt_t          starve_q, starve_d;
    logic          owner_q, owner_d;
    logic          m_we_q, m_we_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic [DW-1:0] c_rdata_q, c_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    logic grant_valid;
    logic grant_owner;

`ifdef MEM_ARB_DMA_LOCK_EN
    localparam cnt_t LockMax = cnt_t'(LOCK_MAX);

    logic lock_q, lock_d;
    cnt_t lock_cnt_q, lock_cnt_d;
`endif

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .c_req       (c_req),
        .d_req       (d_req),
        .starve_cnt  (starve_q),
`ifdef MEM_ARB_DMA_LOCK_EN
        .lock_active (lock_q),
`endif
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        starve_d   = starve_q;
        owner_d    = owner_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        c_rdata_d  = c_rdata_q;
        d_rdata_d  = d_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (!d_req) begin
                    starve_d = '0;
                end
                if (grant_valid) begin
                    state_d = StIssue;
                    owner_d = grant_owner;
                    if (grant_owner == OWNER_DMA) begin
                        m_we_d    = d_we;
                        m_addr_d  = d_addr;
                        m_wdata_d = d_wdata;
                        starve_d  = '0;
                    end else begin
                        m_we_d    = c_we;
                        m_addr_d  = c_addr;
                        m_wdata_d = c_wdata;
                        if (d_req) begin
                            starve_d = sat_inc(starve_q);
                        end
                    end
                end
            end
            StIssue: begin
                wait_cnt_d = MemLatM1;
                state_d    = (MEM_LAT == 1) ? StResp : StWait;
            end
            StWait: begin
                wait_cnt_d = wait_cnt_q - cnt_t'(1);
                if (wait_cnt_q <= cnt_t'(1)) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (owner_q == OWNER_CORE) begin
                    c_rdata_d = m_rdata;
                end else begin
                    d_rdata_d = m_rdata;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            starve_q   <= '0;
            owner_q    <= OWNER_CORE;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            c_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            starve_q   <= starve_d;
            owner_q    <= owner_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            c_rdata_q  <= c_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

`ifdef MEM_ARB_DMA_LOCK_EN
    // Lock is armed by a locked DMA response and counts DMA grants made under it.
    always_comb begin
        lock_d     = lock_q;
        lock_cnt_d = lock_cnt_q;
        if (state_q == StIdle && grant_valid) begin
            if (grant_owner == OWNER_CORE) begin
                lock_d     = 1'b0;
                lock_cnt_d = '0;
            end else if (lock_q) begin
                lock_cnt_d = sat_inc(lock_cnt_q);
            end
        end else if (state_q == StResp) begin
            if (owner_q == OWNER_DMA && d_lock && lock_cnt_q < LockMax) begin
                lock_d = 1'b1;
            end else begin
                lock_d     = 1'b0;
                lock_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lock_q     <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end
`endif

    // Ack and read data are presented in the response cycle itself; a reset
    // arriving in that cycle suppresses the ack.
    assign c_ack   = reset & (state_q == StResp) & (owner_q == OWNER_CORE);
    assign d_ack   = reset & (state_q == StResp) & (owner_q == OWNER_DMA);
    assign c_rdata = c_ack ? m_rdata : c_rdata_q;
    assign d_rdata = d_ack ? m_rdata : d_rdata_q;

    assign m_en    = (state_q == StIssue);
    assign m_we    = m_we_q & m_en;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign busy    = (state_q != StIdle);
    assign owner   = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1 and one at MEM_LAT=3,
// each backed by a fixed-latency memory model returning an address pattern.
module tb_mem_arbiter;

    typedef struct packed {
        logic        rst_n;
        logic        c_req;
        logic        c_we;
        logic [31:0] c_addr;
        logic [31:0] c_wdata;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
    } vin_t;

    typedef struct packed {
        logic        c_ack;
        logic        d_ack;
        logic        m_en;
        logic        m_we;
        logic        busy;
        logic        owner;
        logic [31:0] m_addr;
        logic [31:0] m_wdata;
        logic [31:0] c_rdata;
        logic [31:0] d_rdata;
    } obs_t;

    typedef struct {
        vin_t in;
        obs_t exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
`ifdef MEM_ARB_DMA_LOCK_EN
    logic        d_lock;
`endif

    logic        c_ack_1, d_ack_1, m_en_1, m_we_1, busy_1, owner_1;
    logic [31:0] c_rdata_1, d_rdata_1, m_addr_1, m_wdata_1, m_rdata_1;
    logic        c_ack_3, d_ack_3, m_en_3, m_we_3, busy_3, owner_3;
    logic [31:0] c_rdata_3, d_rdata_3, m_addr_3, m_wdata_3, m_rdata_3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .AW         (32),
        .DW         (32),
        .MEM_LAT    (1),
        .STARVE_MAX (4)
`ifdef MEM_ARB_DMA_LOCK_EN
        ,
        .LOCK_MAX   (2)
`endif
    ) u_dut_l1 (
        .clk     (clk),
        .reset   (reset),
        .c_req   (c_req),
        .c_we    (c_we),
        .c_addr  (c_addr),
        .c_wdata (c_wdata),
        .c_rdata (c_rdata_1),
        .c_ack   (c_ack_1),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata_1),
        .d_ack   (d_ack_1),
        .m_en    (m_en_1),
        .m_we    (m_we_1),
        .m_addr  (m_addr_1),
        .m_wdata (m_wdata_1),
        .m_rdata (m_rdata_1),
        .busy    (busy_1),
        .owner   (owner_1)
`ifdef MEM_ARB_DMA_LOCK_EN
        ,
        .d_lock  (d_lock)
`endif
    );

    mem_arbiter #(
        .AW         (32),
        .DW         (32),
        .MEM_LAT    (3),
        .STARVE_MAX (4)
    ) u_dut_l3 (
        .clk     (clk),
        .reset   (reset),
        .c_req   (c_req),
        .c_we    (c_we),
        .c_addr  (c_addr),
        .c_wdata (c_wdata),
        .c_rdata (c_rdata_3),
        .c_ack   (c_ack_3),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata_3),
        .d_ack   (d_ack_3),
        .m_en    (m_en_3),
        .m_we    (m_we_3),
        .m_addr  (m_addr_3),
        .m_wdata (m_wdata_3),
        .m_rdata (m_rdata_3),
        .busy    (busy_3),
        .owner   (owner_3)
`ifdef MEM_ARB_DMA_LOCK_EN
        ,
        .d_lock  (d_lock)
`endif
    );

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a == 32'h10) ? 32'hE3A0_1005 : (a ^ 32'h5A5A_0000);
    endfunction

    // Memory models: data is valid exactly MEM_LAT cycles after the m_en cycle.
    logic [31:0] pipe1;
    logic [31:0] pipe3 [3];
    always @(posedge clk) begin
        pipe1    <= m_en_1 ? pat(m_addr_1) : 32'h0;
        pipe3[0] <= m_en_3 ? pat(m_addr_3) : 32'h0;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign m_rdata_1 = pipe1;
    assign m_rdata_3 = pipe3[2];

    function automatic vin_t vi(input logic r, input logic cr, input logic cw,
                                input logic [31:0] ca, input logic [31:0] cd,
                                input logic dr, input logic dw,
                                input logic [31:0] da, input logic [31:0] dd);
        return '{rst_n: r, c_req: cr, c_we: cw, c_addr: ca, c_wdata: cd,
                 d_req: dr, d_we: dw, d_addr: da, d_wdata: dd};
    endfunction

    function automatic obs_t vo(input logic ca, input logic da, input logic me,
                                input logic mw, input logic bz, input logic ow,
                                input logic [31:0] ma, input logic [31:0] md,
                                input logic [31:0] cr, input logic [31:0] dr);
        return '{c_ack: ca, d_ack: da, m_en: me, m_we: mw, busy: bz, owner: ow,
                 m_addr: ma, m_wdata: md, c_rdata: cr, d_rdata: dr};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("ack=%b/%b en=%b we=%b busy=%b own=%b addr=%h wd=%h crd=%h drd=%h",
                         o.c_ack, o.d_ack, o.m_en, o.m_we, o.busy, o.owner,
                         o.m_addr, o.m_wdata, o.c_rdata, o.d_rdata);
    endfunction

    function automatic obs_t obs1();
        return vo(c_ack_1, d_ack_1, m_en_1, m_we_1, busy_1, owner_1,
                  m_addr_1, m_wdata_1, c_rdata_1, d_rdata_1);
    endfunction

    function automatic obs_t obs3();
        return vo(c_ack_3, d_ack_3, m_en_3, m_we_3, busy_3, owner_3,
                  m_addr_3, m_wdata_3, c_rdata_3, d_rdata_3);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %s, expected %s", name, fmt(act), fmt(exp));
        end
    endtask

    task automatic apply(input vin_t v);
        reset   = v.rst_n;
        c_req   = v.c_req;
        c_we    = v.c_we;
        c_addr  = v.c_addr;
        c_wdata = v.c_wdata;
        d_req   = v.d_req;
        d_we    = v.d_we;
        d_addr  = v.d_addr;
        d_wdata = v.d_wdata;
    endtask

    task automatic clear_in();
        c_req   = 1'b0;
        c_we    = 1'b0;
        c_addr  = 32'h0;
        c_wdata = 32'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    // Records the owner of every m_en cycle on the MEM_LAT=1 instance and
    // checks that no ack lasts longer than one cycle.
    task automatic check_grants(input string name, input string exp);
        int   got;
        int   cyc;
        logic prev_ack;
        logic [7:0] g;
        got      = 0;
        cyc      = 0;
        prev_ack = 1'b0;
        while (got < exp.len() && cyc < 200) begin
            tick();
            cyc++;
            if (prev_ack) begin
                chk($sformatf("%s_ack_width", name), 32'(c_ack_1 | d_ack_1), 32'h0);
            end
            prev_ack = c_ack_1 | d_ack_1;
            if (m_en_1) begin
                g = owner_1 ? 8'h44 : 8'h43;
                chk($sformatf("%s_grant%0d", name, got), 32'(g), 32'(exp[got]));
                got++;
            end
        end
        if (got < exp.len()) begin
            chk($sformatf("%s_timeout", name), 32'(got), 32'(exp.len()));
        end
    endtask

    vec_t vecs [14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int   ack_at, ack_n, busy_n, men_n;
        logic seen;

        reset = 1'b0;
        clear_in();
`ifdef MEM_ARB_DMA_LOCK_EN
        d_lock = 1'b0;
`endif

        // Cycle-by-cycle vectors on the MEM_LAT=1 instance.
        vecs[0]  = '{vi(0, 0, 0, 32'h00, 0, 0, 0, 32'h00, 0),
                     vo(0, 0, 0, 0, 0, 0, 32'h00, 0, 0, 0)};
        vecs[1]  = '{vi(1, 1, 0, 32'h10, 0, 0, 0, 32'h00, 0),
                     vo(0, 0, 1, 0, 1, 0, 32'h10, 0, 0, 0)};
        vecs[2]  = '{vi(1, 1, 0, 32'h10, 0, 0, 0, 32'h00, 0),
                     vo(1, 0, 0, 0, 1, 0, 32'h10, 0, 32'hE3A01005, 0)};
        vecs[3]  = '{vi(1, 0, 0, 32'h10, 0, 0, 0, 32'h00, 0),
                     vo(0, 0, 0, 0, 0, 0, 32'h10, 0, 32'hE3A01005, 0)};
        vecs[4]  = '{vi(1, 0, 0, 32'h00, 0, 0, 0, 32'h00, 0),
                     vo(0, 0, 0, 0, 0, 0, 32'h10, 0, 32'hE3A01005, 0)};
        vecs[5]  = '{vi(1, 1, 0, 32'h20, 0, 1, 0, 32'h44, 0),
                     vo(0, 0, 1, 0, 1, 0, 32'h20, 0, 32'hE3A01005, 0)};
        vecs[6]  = '{vi(1, 1, 0, 32'h20, 0, 1, 0, 32'h44, 0),
                     vo(1, 0, 0, 0, 1, 0, 32'h20, 0, 32'h5A5A0020, 0)};
        vecs[7]  = '{vi(1, 0, 0, 32'h20, 0, 1, 0, 32'h44, 0),
                     vo(0, 0, 0, 0, 0, 0, 32'h20, 0, 32'h5A5A0020, 0)};
        vecs[8]  = '{vi(1, 0, 0, 32'h20, 0, 1, 0, 32'h44, 0),
                     vo(0, 0, 1, 0, 1, 1, 32'h44, 0, 32'h5A5A0020, 0)};
        vecs[9]  = '{vi(1, 0, 0, 32'h20, 0, 1, 0, 32'h44, 0),
                     vo(0, 1, 0, 0, 1, 1, 32'h44, 0, 32'h5A5A0020, 32'h5A5A0044)};
        vecs[10] = '{vi(1, 0, 0, 32'h00, 0, 0, 0, 32'h00, 0),
                     vo(0, 0, 0, 0, 0, 1, 32'h44, 0, 32'h5A5A0020, 32'h5A5A0044)};
        vecs[11] = '{vi(1, 0, 0, 32'h00, 0, 1, 1, 32'h80, 32'h12345678),
                     vo(0, 0, 1, 1, 1, 1, 32'h80, 32'h12345678, 32'h5A5A0020, 32'h5A5A0044)};
        vecs[12] = '{vi(1, 0, 0, 32'h00, 0, 1, 1, 32'h80, 32'h12345678),
                     vo(0, 1, 0, 0, 1, 1, 32'h80, 32'h12345678, 32'h5A5A0020, 32'h5A5A0080)};
        vecs[13] = '{vi(1, 0, 0, 32'h00, 0, 0, 0, 32'h00, 0),
                     vo(0, 0, 0, 0, 0, 1, 32'h80, 32'h12345678, 32'h5A5A0020, 32'h5A5A0080)};

        for (int i = 0; i < 14; i++) begin
            apply(vecs[i].in);
            tick();
            chk_obs($sformatf("vec%0d", i), obs1(), vecs[i].exp);
        end

        // Continuous contention: starvation relief every fifth grant.
        do_reset();
        c_req  = 1'b1;
        c_addr = 32'h100;
        d_req  = 1'b1;
        d_addr = 32'h200;
        check_grants("contend", "CCCCDCCCCD");
        clear_in();

`ifdef MEM_ARB_DMA_LOCK_EN
        do_reset();
        d_lock = 1'b1;
        c_req  = 1'b1;
        c_addr = 32'h100;
        d_req  = 1'b1;
        d_addr = 32'h200;
        check_grants("lock", "CCCCDDDC");
        clear_in();
        d_lock = 1'b0;
`endif

        // DMA write on the MEM_LAT=3 instance.
        do_reset();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h40;
        d_wdata = 32'hDEADBEEF;
        ack_at  = -1;
        ack_n   = 0;
        busy_n  = 0;
        men_n   = 0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (m_en_3) begin
                men_n++;
                chk("wr_men_cycle", 32'(t), 32'd1);
                chk("wr_m_we", 32'(m_we_3), 32'd1);
                chk("wr_m_addr", m_addr_3, 32'h40);
                chk("wr_m_wdata", m_wdata_3, 32'hDEADBEEF);
            end
            if (busy_3) busy_n++;
            if (c_ack_3) chk("wr_c_ack", 32'(c_ack_3), 32'd0);
            if (d_ack_3) begin
                ack_n++;
                if (ack_at < 0) ack_at = t;
                clear_in();
            end
        end
        chk("wr_ack_cycle", 32'(ack_at), 32'd4);
        chk("wr_ack_count", 32'(ack_n), 32'd1);
        chk("wr_busy_cycles", 32'(busy_n), 32'd4);
        chk("wr_men_count", 32'(men_n), 32'd1);

        // Core drops its request mid-transaction; inputs after the grant are ignored.
        do_reset();
        c_req  = 1'b1;
        c_addr = 32'h30;
        tick();
        chk("drop_issue", 32'(m_en_3), 32'd1);
        tick();
        c_req   = 1'b0;
        c_addr  = 32'h99;
        c_wdata = 32'hFFFF_FFFF;
        tick();
        chk("drop_wait_noack", 32'(c_ack_3), 32'd0);
        tick();
        chk("drop_ack", 32'(c_ack_3), 32'd1);
        chk("drop_rdata", c_rdata_3, pat(32'h30));
        chk("drop_m_addr", m_addr_3, 32'h30);
        d_req  = 1'b1;
        d_addr = 32'h50;
        tick();
        chk("drop_idle", 32'({busy_3, c_ack_3}), 32'd0);
        tick();
        chk("drop_next_owner", 32'({m_en_3, owner_3}), 32'd3);
        chk("drop_next_addr", m_addr_3, 32'h50);
        clear_in();

        // Reset asserted during the wait phase aborts without an ack.
        do_reset();
        c_req  = 1'b1;
        c_addr = 32'h60;
        tick();
        chk("abort_issue", 32'(m_en_3), 32'd1);
        tick();
        reset = 1'b0;
        c_req = 1'b0;
        tick();
        chk_obs("abort_state", obs3(), vo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;
        seen  = 1'b0;
        for (int t = 0; t < 8; t++) begin
            tick();
            seen = seen | c_ack_3 | d_ack_3 | m_en_3;
        end
        chk("abort_no_ack", 32'(seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single unified instruction/data memory of the multicycle ARM core between two requesters.
- Requester 0 is the core: fetch and LDR/STR, driven by the main FSM's memory state.
- Requester 1 is the program-loader/DMA port.
- Sequences every memory access through a fixed-latency issue/wait/respond FSM and returns read data plus a one-cycle ack; the core FSM stalls in its memory state until ack.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MEM_LAT, 1, cycles from m_en to valid m_rdata; legal range 1..15.
- STARVE_MAX, 4, consecutive lost arbitrations after which DMA wins over the core; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- c_req  in  1  core request; held with c_we/c_addr/c_wdata until c_ack.
- c_we  in  1  core write enable.
- c_addr  in  AW  core address.
- c_wdata  in  DW  core write data.
- c_rdata  out  DW  core read data, valid in the c_ack cycle.
- c_ack  out  1  core transaction complete, one-cycle pulse.
- d_req, d_we, d_addr, d_wdata, d_rdata, d_ack  same as c_* for DMA.
- m_en  out  1  memory access strobe, one cycle per transaction.
- m_we  out  1  memory write enable, qualified by m_en.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_rdata  in  DW  memory read data, valid MEM_LAT cycles after m_en.
- busy  out  1  FSM not in IDLE.
- owner  out  1  0 = core, 1 = DMA; the last or current grant.

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE.
  - m_en, m_we, c_ack, d_ack, busy, owner all 0.
  - c_rdata, d_rdata, m_addr, m_wdata all 0.
  - Starvation counter and wait counter 0.
- IDLE, no request: stay in IDLE.
- IDLE, one or both requests: arbitrate.
  - Winner is the core, unless d_req is high and starve_cnt >= STARVE_MAX, in which case DMA wins.
  - Latch the winner's we/addr/wdata into m_* registers, set owner, go to ISSUE.
- ISSUE: m_en=1 for exactly this cycle; wait counter loaded with MEM_LAT-1.
  - MEM_LAT==1: go to RESP.
  - Otherwise: go to WAIT.
- WAIT: decrement the wait counter; go to RESP when it reaches 0. m_en=0.
- RESP:
  - Capture m_rdata into the owner's rdata register; writes also capture it, with the value unspecified.
  - Pulse the owner's ack for one cycle; go to IDLE.
  - The other requester's ack and rdata are unchanged.
- Latency: request sampled in IDLE at edge N → m_en high in cycle N+1 → ack in cycle N+1+MEM_LAT.
  - MEM_LAT=1 gives ack 2 cycles after the arbitration edge.
- Throughput: at least one IDLE cycle between transactions.
  - A req still high in the cycle after ack is treated as a new request.
- Starvation counter (saturating at 15):
  - Increments when the core wins while d_req=1.
  - Cleared when DMA wins or when d_req=0 in IDLE.
- Boundary conditions:
  - Simultaneous requests with starve_cnt < STARVE_MAX: core wins.
  - Requester drops req mid-transaction: the transaction completes and the ack still pulses. m_* are latched, so input changes after the grant are ignored.
  - Reset asserted in ISSUE/WAIT/RESP: abort immediately. No ack is generated, m_en=0 from the next cycle.
  - c_req and d_req both low in RESP: normal return to IDLE.

Optional Feature:
- Macro MEM_ARB_DMA_LOCK_EN. Adds input d_lock (1 bit) and parameter LOCK_MAX (default 8).
- With the macro:
  - If owner=1 and d_lock=1 in the RESP cycle, the next IDLE arbitration grants DMA whenever d_req=1, regardless of c_req.
  - The lock holds for at most LOCK_MAX consecutive DMA transactions; the next arbitration then follows normal rules.
  - A lock counter counts the locked transactions. It clears when the lock ends or when the core wins.
- Without the macro: no d_lock port, no lock counter; arbitration is exactly as above.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding IDLE/ISSUE/WAIT/RESP (2 bits);
  - OWNER_CORE=0, OWNER_DMA=1;
  - counter widths (4 bits).
- One natural sub-module: mem_arb_prio, combinational winner select from c_req, d_req, starve_cnt (and lock state when enabled).
- FSM, counters and data registers stay in mem_arbiter.

Test Plan:
- Core read, MEM_LAT=1: c_req=1, c_addr=0x10, memory returns 0xE3A01005 → m_en one cycle with m_addr=0x10; c_ack 2 cycles after the request edge with c_rdata=0xE3A01005; d_ack stays 0.
- DMA write, MEM_LAT=3: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF → m_en=1, m_we=1, m_wdata=0xDEADBEEF for one cycle; d_ack 4 cycles after the grant edge; busy high for 4 cycles.
- Contention, STARVE_MAX=4: c_req and d_req held high continuously → grant order C,C,C,C,D,C,C,C,C,D; every ack is one cycle long.
- Req dropped: c_req deasserted in the WAIT cycle (MEM_LAT=3) → c_ack still pulses at the expected cycle; the next arbitration ignores the core.
- Reset mid-transaction: reset=0 in the WAIT cycle → next cycle state=IDLE with all outputs 0; no ack is ever issued for the aborted access.
- With MEM_ARB_DMA_LOCK_EN, LOCK_MAX=2: d_lock=1, both reqs held high after a DMA win → D,D,D then C. The initial DMA win plus 2 locked transactions precede the core grant.
